// File: rtl/mem_port_arbiter.sv
// Multi-channel arbiter for a shared single-port memory bus.
// Optional handshake timeout enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH-1:0]            req_write,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*WORD_SIZE-1:0]  req_wdata,
  output logic [NUM_CH-1:0]            req_ready,
  output logic [NUM_CH-1:0]            resp_valid,
  output logic [WORD_SIZE-1:0]         resp_rdata,
  output logic                         resp_err,
  output logic                         busy,
  output logic                         readM,
  output logic                         writeM,
  output logic [ADDR_WIDTH-1:0]        address,
  inout  wire  [WORD_SIZE-1:0]         data,
  input  logic                         inputReady,
  input  logic                         ackOutput
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, RESP
  } state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [WORD_SIZE-1:0]  rdata_q, rdata_d;

  logic                  gnt_any;
  logic [CH_W-1:0]       gnt_idx;
  logic [NUM_CH-1:0]     gnt_oh;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [WORD_SIZE-1:0]  gnt_wdata;
  logic                  gnt_write;
  logic                  tmo;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Scan high to low so the lowest valid index wins.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    gnt_write = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_any   = 1'b1;
        gnt_idx   = CH_W'(i);
        gnt_oh    = NUM_CH'(1) << i;
        gnt_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_wdata = req_wdata[i*WORD_SIZE +: WORD_SIZE];
        gnt_write = req_write[i];
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  assign tmo = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          ch_d    = gnt_idx;
          addr_d  = gnt_addr;
          wdata_d = gnt_wdata;
          write_d = gnt_write;
          state_d = gnt_write ? WRITE : READ;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      READ: begin
        if (inputReady) begin
          rdata_d = data;
          state_d = RESP;
        end else if (tmo) begin
          rdata_d = '0;
          state_d = RESP;
`ifdef MEM_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      WRITE: begin
        if (ackOutput) begin
          state_d = RESP;
        end else if (tmo) begin
          state_d = RESP;
`ifdef MEM_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign readM   = (state_q == READ);
  assign writeM  = (state_q == WRITE);
  assign address = (readM || writeM) ? addr_q : '0;
  assign data    = writeM ? wdata_q : {WORD_SIZE{1'bz}};

  assign req_ready  = (state_q == IDLE && !reset) ? gnt_oh : '0;
  assign resp_valid = (state_q == RESP) ? (NUM_CH'(1) << ch_q) : '0;
  // Writes report zero data; reads expose the last captured word.
  assign resp_rdata = (state_q == RESP && write_q) ? '0 : rdata_q;

`ifdef MEM_TIMEOUT_EN
  assign resp_err = (state_q == RESP) && err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised memory-port controller between NUM_CH internal requesters and the shared single-port memory bus: readM, writeM, address, inout data, inputReady, ackOutput.
- Typical requesters: channel 0 = instruction fetch, channel 1 = data access in the multi-cycle CPU.
- Arbitrates among requesters, runs one bus transaction at a time with the memory handshake, and returns read data and a completion pulse to the granted channel.

Parameters:
- WORD_SIZE, 16, data width in bits.
- ADDR_WIDTH, 16, address width in bits.
- NUM_CH, 2, number of requester channels (1..8).
- TIMEOUT, 15, handshake wait limit in cycles (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_CH  per-channel request; held high until req_ready.
- req_write  input  NUM_CH  1 = write, 0 = read.
- req_addr  input  NUM_CH*ADDR_WIDTH  flattened addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_CH*WORD_SIZE  flattened write data, same slicing.
- req_ready  output  NUM_CH  one-hot accept pulse.
- resp_valid  output  NUM_CH  one-hot completion pulse.
- resp_rdata  output  WORD_SIZE  read data; valid while resp_valid is high.
- resp_err  output  1  timeout flag; qualified by resp_valid.
- busy  output  1  high when state is not IDLE.
- readM  output  1  memory read strobe.
- writeM  output  1  memory write strobe.
- address  output  ADDR_WIDTH  memory address.
- data  inout  WORD_SIZE  shared data bus.
- inputReady  input  1  memory read data valid.
- ackOutput  input  1  memory write accepted.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state = IDLE. All of the following are 0: readM, writeM, address, req_ready, resp_valid, resp_rdata, resp_err, busy. data is high-Z. Latched channel, address, write data and write flag are cleared.
- FSM states: IDLE, READ, WRITE, RESP. State is held in a register; strobes are decoded from the state register only and are never combinational from inputs.
- IDLE:
  - If any req_valid bit is high, grant the lowest-index valid channel g and assert req_ready[g] combinationally in that cycle.
  - At the clock edge, latch addr, wdata and write for channel g, then go to WRITE if write = 1, else READ.
  - With no valid request, stay in IDLE.
  - inputReady and ackOutput are ignored in IDLE.
- READ:
  - readM = 1, address = latched address, data = high-Z.
  - When inputReady = 1, capture data into resp_rdata and go to RESP.
  - Otherwise stay in READ.
- WRITE:
  - writeM = 1, address = latched address, data driven with the latched write data.
  - When ackOutput = 1, go to RESP.
  - Otherwise stay in WRITE.
- RESP:
  - resp_valid[g] = 1 for exactly one cycle, then go to IDLE.
  - For a write, resp_rdata = 0.
  - For a read, resp_rdata holds the captured word until the next read capture.
- Latency: with the memory responding in its first strobe cycle, req_ready is at cycle 0 (IDLE), the strobe at cycle 1 and resp_valid at cycle 2. Back-to-back throughput is one transaction per 3 cycles.
- Address and write data stay stable for the whole strobe phase, even if the requester changes its inputs after req_ready.
- Simultaneous requests: the lower index wins; the losing channel stays pending and is granted in the next IDLE cycle.
- Reset mid-transaction: at the reset edge, go to IDLE and drop the strobes. No resp_valid is issued for the aborted transaction.
- Only one of readM and writeM is ever high. data is driven only in WRITE.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A cycle counter clears on entry to READ or WRITE and increments every strobe cycle.
  - If it reaches TIMEOUT with no handshake, go to RESP with resp_err = 1 and resp_rdata = 0.
  - A handshake that arrives in the same cycle the counter reaches TIMEOUT wins: normal completion with resp_err = 0.
- MEM_TIMEOUT_EN undefined: no counter is built; READ and WRITE wait indefinitely; resp_err is tied to 0.

Test Plan:
1. Reset, then channel 0 read of address 0x0010; memory asserts inputReady with data 0xBEEF in the first READ cycle. Required: req_ready[0] at cycle 0, readM=1 and address=0x0010 at cycle 1, resp_valid[0]=1 and resp_rdata=0xBEEF at cycle 2.
2. Channel 1 write of 0x1234 to 0x0040; ackOutput delayed 3 cycles. Required: writeM=1 and data=0x1234 held for 4 cycles, then one resp_valid[1] pulse with resp_rdata=0 and busy falling one cycle later.
3. Channels 0 and 1 request in the same cycle. Required: channel 0 is served first; req_ready[1] arrives in the IDLE cycle after resp_valid[0]; no overlapping strobes.
4. Assert reset during the READ wait. Required: next cycle readM=0, busy=0, data high-Z, and no resp_valid.
5. inputReady pulsed while IDLE with no requests. Required: state remains IDLE and all outputs stay 0.
6. With MEM_TIMEOUT_EN and TIMEOUT=15, a read that is never acknowledged. Required: resp_valid with resp_err=1 after 15 READ cycles. Repeat with inputReady arriving on the 15th cycle: resp_err=0 and data is captured.
